// File: rtl/opb_regbank_pkg.sv
// Shared definitions for the OPB register bank: CTRL bit layout, slave FSM
// encoding and the OPB (bit 0 = MSB) to user (bit 31 = MSB) lane mapping.
package opb_regbank_pkg;

    localparam int CTRL_COMMIT    = 0;
    localparam int CTRL_AUTO      = 1;
    localparam int CTRL_COUNT_LSB = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } slv_state_e;

    // OPB bit i carries user bit 31-i.
    function automatic logic [31:0] opb_to_user(input logic [0:31] d);
        logic [31:0] u;
        for (int i = 0; i < 32; i++) begin
            u[31-i] = d[i];
        end
        return u;
    endfunction

    function automatic logic [0:31] user_to_opb(input logic [31:0] u);
        logic [0:31] d;
        for (int i = 0; i < 32; i++) begin
            d[i] = u[31-i];
        end
        return d;
    endfunction

    // BE[k] enables OPB lane DBus[8k:8k+7], i.e. user bits 31-8k downto 24-8k.
    function automatic logic [31:0] be_to_mask(input logic [0:3] be);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) begin
            m[31-8*k -: 8] = {8{be[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus bundle; the master modport is the bus/testbench view.
interface opb_register_bank_ppc2simulink_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_regbank_slave_if.sv
// OPB slave front end: address decode, two-state ack FSM, transfer capture
// and readback mux. Produces a single-cycle write request for the bank.
module opb_regbank_slave_if
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0108D800,
    parameter logic [31:0] C_HIGHADDR = 32'h0108D8FF,
    parameter int          N_REGS     = 4,
    parameter int          IDX_W      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    opb_register_bank_ppc2simulink_if.slave opb,
    input  logic [N_REGS*32-1:0]    rd_shadow,
    input  logic [31:0]             ctrl_rd,
    output logic                    wr_en,
    output logic                    wr_is_data,
    output logic                    wr_is_ctrl,
    output logic [IDX_W-1:0]        wr_idx,
    output logic [31:0]             wr_data,
    output logic [31:0]             wr_mask
);

    slv_state_e  state_q, state_d;
    logic [29:0] widx_q, widx_d;
    logic [31:0] data_q, data_d;
    logic [0:3]  be_q, be_d;
    logic        rnw_q, rnw_d;

    logic        hit;
    logic [31:0] offset;
    logic        ack;
    logic [31:0] rd_user;
    logic [2:0]  unused_bits;

    assign offset      = opb.OPB_ABus - C_BASEADDR;
    assign hit         = opb.OPB_select && (opb.OPB_ABus >= C_BASEADDR) && (opb.OPB_ABus <= C_HIGHADDR);
    assign unused_bits = {opb.OPB_seqAddr, offset[1:0]};

    // Ack is masked by reset so a reset landing in ACK aborts with no ack.
    assign ack        = (state_q == ST_ACK) && !rst;
    assign wr_is_data = widx_q < 30'(N_REGS);
    assign wr_is_ctrl = widx_q == 30'(N_REGS);
    assign wr_idx     = widx_q[IDX_W-1:0];
    assign wr_en      = ack && !rnw_q;
    assign wr_data    = data_q;
    assign wr_mask    = be_to_mask(be_q);

    assign opb.Sl_xferAck = ack;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    // Next state and capture of the transfer on the IDLE->ACK edge.
    always_comb begin
        state_d = state_q;
        widx_d  = widx_q;
        data_d  = data_q;
        be_d    = be_q;
        rnw_d   = rnw_q;
        if (state_q == ST_IDLE) begin
            if (hit) begin
                state_d = ST_ACK;
                widx_d  = offset[31:2];
                data_d  = opb_to_user(opb.OPB_DBus);
                be_d    = opb.OPB_BE;
                rnw_d   = opb.OPB_RNW;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured transfer fields; only meaningful while in ACK.
    always_ff @(posedge clk) begin
        widx_q <= widx_d;
        data_q <= data_d;
        be_q   <= be_d;
        rnw_q  <= rnw_d;
    end

    // Readback mux: shadow for data words, CTRL image, zero for reserved.
    always_comb begin
        rd_user = '0;
        if (wr_is_data) begin
            rd_user = rd_shadow[32*int'(wr_idx) +: 32];
        end else if (wr_is_ctrl) begin
            rd_user = ctrl_rd;
        end
        opb.Sl_DBus = (ack && rnw_q) ? user_to_opb(rd_user) : '0;
    end

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// Double-buffered OPB register bank: software writes shadows, a commit (or
// auto-commit on each data write) copies them to the user-facing outputs.
module opb_register_bank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0108D800,
    parameter logic [31:0] C_HIGHADDR   = 32'h0108D8FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          N_REGS       = 4,
    parameter logic [31:0] INIT_VALUE   = 32'h0
) (
    input  logic                 OPB_Clk,
    input  logic                 OPB_Rst,
    opb_register_bank_ppc2simulink_if.slave opb,
    output logic [N_REGS*32-1:0] user_data_out,
    output logic                 user_update,
    output logic [15:0]          commit_count
);

    localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    if (C_OPB_DWIDTH != 32 || C_OPB_AWIDTH != 32) begin : g_bad_width
        $error("opb_register_bank_ppc2simulink: only 32-bit OPB is supported");
    end
    if (N_REGS < 1 || N_REGS > 64) begin : g_bad_nregs
        $error("opb_register_bank_ppc2simulink: N_REGS must be 1..64");
    end
    if ((longint'(C_HIGHADDR) - longint'(C_BASEADDR) + 1) < longint'(4 * (N_REGS + 1))) begin : g_bad_window
        $error("opb_register_bank_ppc2simulink: address window too small for N_REGS+1 words");
    end

    logic [31:0] shadow_q [N_REGS];
    logic [31:0] shadow_d [N_REGS];
    logic [31:0] active_q [N_REGS];
    logic [31:0] active_d [N_REGS];
    logic        auto_q, auto_d;
    logic [15:0] commit_count_q, commit_count_d;
    logic        user_update_q, user_update_d;

    logic [N_REGS*32-1:0] rd_shadow;
    logic [31:0]          ctrl_rd;
    logic                 wr_en, wr_is_data, wr_is_ctrl;
    logic [IDX_W-1:0]     wr_idx;
    logic [31:0]          wr_data, wr_mask;
    logic [31:0]          merged;

    for (genvar k = 0; k < N_REGS; k++) begin : g_flat
        assign rd_shadow[32*k +: 32]     = shadow_q[k];
        assign user_data_out[32*k +: 32] = active_q[k];
    end

    assign ctrl_rd      = {commit_count_q, 14'b0, auto_q, 1'b0};
    assign user_update  = user_update_q;
    assign commit_count = commit_count_q;

    opb_regbank_slave_if #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR),
        .N_REGS     (N_REGS),
        .IDX_W      (IDX_W)
    ) u_slave (
        .clk        (OPB_Clk),
        .rst        (OPB_Rst),
        .opb        (opb),
        .rd_shadow  (rd_shadow),
        .ctrl_rd    (ctrl_rd),
        .wr_en      (wr_en),
        .wr_is_data (wr_is_data),
        .wr_is_ctrl (wr_is_ctrl),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask)
    );

    // Shadow byte merge, auto-commit and explicit commit. A CTRL write with
    // COMMIT and AUTO together commits once; AUTO only affects later writes.
    always_comb begin
        for (int k = 0; k < N_REGS; k++) begin
            shadow_d[k] = shadow_q[k];
            active_d[k] = active_q[k];
        end
        auto_d         = auto_q;
        commit_count_d = commit_count_q;
        user_update_d  = 1'b0;
        merged         = '0;
        if (wr_en && wr_is_data) begin
            merged           = (shadow_q[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
            shadow_d[wr_idx] = merged;
            if (auto_q) begin
                active_d[wr_idx] = merged;
                user_update_d    = 1'b1;
                commit_count_d   = commit_count_q + 16'd1;
            end
        end
        if (wr_en && wr_is_ctrl) begin
            if (wr_mask[CTRL_AUTO]) begin
                auto_d = wr_data[CTRL_AUTO];
            end
            if (wr_mask[CTRL_COMMIT] && wr_data[CTRL_COMMIT]) begin
                for (int k = 0; k < N_REGS; k++) begin
                    active_d[k] = shadow_q[k];
                end
                user_update_d  = 1'b1;
                commit_count_d = commit_count_q + 16'd1;
            end
        end
    end

    // Bank state; everything software-visible returns to its reset value.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            for (int k = 0; k < N_REGS; k++) begin
                shadow_q[k] <= INIT_VALUE;
                active_q[k] <= INIT_VALUE;
            end
            auto_q         <= 1'b0;
            commit_count_q <= 16'd0;
            user_update_q  <= 1'b0;
        end else begin
            for (int k = 0; k < N_REGS; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
            end
            auto_q         <= auto_d;
            commit_count_q <= commit_count_d;
            user_update_q  <= user_update_d;
        end
    end

endmodule
